// File: rtl/svo_dec.sv
// svo_dec: recovers the active-pixel AXI-Stream and the frame geometry from a timed SVO video stream
// Ports:
//   clk, resetn               clock, synchronous active-low reset
//   in_axis_t{valid,ready,data,user}   timed stream; tuser = {blank, vsync, hsync, sof}
//   out_axis_t{valid,ready,data,user}  active pixels; tuser[0] marks the first pixel of a frame
//   locked                    decoder is synchronised to a frame start
//   err_geom, err_count       geometry mismatch pulse and saturating count
//   meas_width, meas_height   active pixels of the last line / active lines of the last frame
// Optional: define SVO_DEC_GEOM_CHECK_EN to flag geometry mismatches and drop lock on them.
`ifndef SVO_XYBITS
`define SVO_XYBITS 14
`endif
module svo_dec #(
  parameter logic [71:0] SVO_MODE = "640x480",
  parameter int SVO_FRAMERATE = 60,
  parameter int SVO_BITS_PER_PIXEL = 24,
  parameter int SVO_BITS_PER_RED = 8,
  parameter int SVO_BITS_PER_GREEN = 8,
  parameter int SVO_BITS_PER_BLUE = 8,
  parameter int SVO_BITS_PER_ALPHA = 0
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_axis_tvalid,
  output logic                          in_axis_tready,
  input  logic [SVO_BITS_PER_PIXEL-1:0] in_axis_tdata,
  input  logic [3:0]                    in_axis_tuser,
  output logic                          out_axis_tvalid,
  input  logic                          out_axis_tready,
  output logic [SVO_BITS_PER_PIXEL-1:0] out_axis_tdata,
  output logic [0:0]                    out_axis_tuser,
  output logic                          locked,
  output logic                          err_geom,
  output logic [7:0]                    err_count,
  output logic [`SVO_XYBITS-1:0]        meas_width,
  output logic [`SVO_XYBITS-1:0]        meas_height
);
  localparam int XY = `SVO_XYBITS;
  localparam int DW = SVO_BITS_PER_PIXEL + 1;
  localparam int HOR_PX = SVO_MODE == 72'("64x48") ? 64 : SVO_MODE == 72'("800x480") ? 800 :
    SVO_MODE == 72'("800x600") ? 800 : SVO_MODE == 72'("1024x768") ? 1024 :
    SVO_MODE == 72'("1280x720") ? 1280 : SVO_MODE == 72'("1920x1080") ? 1920 : 640;
  localparam int VER_PX = SVO_MODE == 72'("64x48") ? 48 : SVO_MODE == 72'("800x600") ? 600 :
    SVO_MODE == 72'("1024x768") ? 768 : SVO_MODE == 72'("1280x720") ? 720 :
    SVO_MODE == 72'("1920x1080") ? 1080 : 480;
  localparam logic [XY-1:0] SVO_HOR_PIXELS = XY'(HOR_PX);
  localparam logic [XY-1:0] SVO_VER_PIXELS = XY'(VER_PX);

  typedef enum logic {HUNT, LOCK} state_t;
  state_t r_state, w_state_nxt;

  logic [DW-1:0] r_mem [4];
  logic [1:0] r_wp, r_rp;
  logic [2:0] r_fill, w_fill_nxt;
  logic r_in_ready, r_out_valid, r_out_user, r_locked, r_err_geom;
  logic r_first, r_prev_nb, r_seen_sof;
  logic [SVO_BITS_PER_PIXEL-1:0] r_out_data;
  logic [7:0] r_err_count;
  logic [XY-1:0] r_col, r_row, r_meas_w, r_meas_h;
  logic w_beat, w_sof, w_blank, w_act, w_sof_act, w_push, w_pop, w_line_end, w_height, w_err;
  logic w_unused;

  assign w_beat     = in_axis_tvalid && r_in_ready;
  assign w_sof      = in_axis_tuser[0];
  assign w_blank    = in_axis_tuser[3];
  // a sof beat in HUNT is already treated as a locked beat
  assign w_act      = w_beat && (r_state == LOCK || w_sof);
  assign w_sof_act  = w_act && w_sof;
  assign w_push     = w_act && !w_blank;
  assign w_line_end = w_act && w_blank && r_prev_nb;
  assign w_height   = w_sof_act && r_seen_sof && r_state == LOCK;
  assign w_pop      = r_fill != 3'd0 && (!r_out_valid || out_axis_tready);
  assign w_fill_nxt = r_fill + {2'b0, w_push} - {2'b0, w_pop};
`ifdef SVO_DEC_GEOM_CHECK_EN
  assign w_err = (w_line_end && r_col != SVO_HOR_PIXELS) || (w_height && r_row != SVO_VER_PIXELS);
`else
  assign w_err = 1'b0;
`endif
  assign w_unused = ^{in_axis_tuser[2:1], SVO_HOR_PIXELS, SVO_VER_PIXELS} ^ (SVO_FRAMERATE == 0) ^
    (SVO_BITS_PER_RED == 0) ^ (SVO_BITS_PER_GREEN == 0) ^ (SVO_BITS_PER_BLUE == 0) ^
    (SVO_BITS_PER_ALPHA == 0);

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= HUNT;
    else r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_err ? HUNT : w_act ? LOCK : r_state;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {w_sof || r_first, in_axis_tdata};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_fill      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_user  <= 1'b0;
      r_out_data  <= '0;
      r_locked    <= 1'b0;
      r_err_geom  <= 1'b0;
      r_err_count <= '0;
      r_first     <= 1'b0;
      r_prev_nb   <= 1'b0;
      r_seen_sof  <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
      r_meas_w    <= '0;
      r_meas_h    <= '0;
    end else begin
      // fill <= 2 after this cycle leaves room for one more beat accepted under the registered ready
      r_in_ready  <= (w_fill_nxt <= 3'd2);
      r_fill      <= w_fill_nxt;
      r_locked    <= r_state == LOCK;
      r_out_valid <= w_pop || (r_out_valid && !out_axis_tready);
      r_err_geom  <= w_err;
      r_seen_sof  <= w_sof_act || (r_seen_sof && r_state == LOCK);
      if (w_push) r_wp <= r_wp + 2'd1;
      if (w_pop) begin
        {r_out_user, r_out_data} <= r_mem[r_rp];
        r_rp <= r_rp + 2'd1;
      end
      if (w_err && r_err_count != 8'hff) r_err_count <= r_err_count + 8'd1;
      if (w_beat) r_prev_nb <= w_push;
      if (w_line_end) r_meas_w <= r_col;
      if (w_height) r_meas_h <= r_row;
      r_first <= w_sof_act ? w_blank : w_push ? 1'b0 : r_first;
      r_col   <= w_sof_act ? XY'(!w_blank) : w_line_end ? '0 :
                 (w_push && !(&r_col)) ? r_col + 1'b1 : r_col;
      r_row   <= w_sof_act ? '0 : (w_line_end && !(&r_row)) ? r_row + 1'b1 : r_row;
    end
  end

  assign in_axis_tready  = r_in_ready;
  assign out_axis_tvalid = r_out_valid;
  assign out_axis_tdata  = r_out_data;
  assign out_axis_tuser  = r_out_user;
  assign locked          = r_locked;
  assign err_geom        = r_err_geom;
  assign err_count       = r_err_count;
  assign meas_width      = r_meas_w;
  assign meas_height     = r_meas_h;
endmodule

// File: tb/tb_svo_dec.sv
// tb_svo_dec: directed self-checking bench for svo_dec in the 64x48 mode
`ifndef SVO_XYBITS
`define SVO_XYBITS 14
`endif
module tb_svo_dec;
  logic clk = 1'b0, resetn = 1'b0;
  logic in_v = 1'b0, in_r, out_v, out_r = 1'b1, locked, err_geom;
  logic [23:0] in_d = '0, out_d;
  logic [3:0] in_u = '0;
  logic [0:0] out_u;
  logic [7:0] err_count;
  logic [`SVO_XYBITS-1:0] meas_w, meas_h;
  int n_chk = 0, n_fail = 0, out_cnt = 0, err_pulses = 0, rdy_mode = 0, rdy_cnt = 0;
  bit saw_stall = 0, m_lock = 0, m_first = 0, m_prev_nb = 0;
  int m_col = 0;
  logic [23:0] pix = 24'h100;
  logic [24:0] exp_q [$];

  svo_dec #(.SVO_MODE("64x48")) dut (
    .clk(clk), .resetn(resetn),
    .in_axis_tvalid(in_v), .in_axis_tready(in_r), .in_axis_tdata(in_d), .in_axis_tuser(in_u),
    .out_axis_tvalid(out_v), .out_axis_tready(out_r), .out_axis_tdata(out_d), .out_axis_tuser(out_u),
    .locked(locked), .err_geom(err_geom), .err_count(err_count),
    .meas_width(meas_w), .meas_height(meas_h)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    rdy_cnt = rdy_cnt + 1;
    out_r = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (rdy_cnt % 3 == 0) : 1'b0;
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (out_v && out_r) begin
        out_cnt++;
        chk("px_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("px", {out_u, out_d}, exp_q.pop_front());
      end
      if (err_geom) err_pulses++;
      if (rdy_mode == 1 && !in_r) saw_stall = 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input bit sof, input bit blank);
    bit acc = 0;
    in_v = 1'b1;
    in_u = {blank, 2'b00, sof};
    in_d = blank ? 24'hbad000 : pix;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = in_r;
      @(posedge clk);
      #1;
    end
    in_v = 1'b0;
    if (!acc) chk("in_accept", acc, 1);
    if (sof) begin
      m_lock = 1;
      m_first = 1;
      m_col = 0;
    end else if (m_lock && blank && m_prev_nb) begin
`ifdef SVO_DEC_GEOM_CHECK_EN
      if (m_col != 64) m_lock = 0;
`endif
      m_col = 0;
    end
    if (m_lock && !blank) begin
      exp_q.push_back({m_first, pix});
      m_first = 0;
      m_col++;
    end
    m_prev_nb = !blank;
    if (!blank) pix++;
  endtask

  task automatic line(input int n);
    for (int i = 0; i < n; i++) send(0, 0);
    for (int i = 0; i < 4; i++) send(0, 1);
  endtask

  task automatic frame_body(input int last_px);
    send(0, 1);
    send(0, 1);
    for (int l = 0; l < 48; l++) line(l == 47 ? last_px : 64);
  endtask

  task automatic drain;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(1);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_in_ready"}, in_r, 0);
    chk({p, "_out_valid"}, out_v, 0);
    chk({p, "_out_data"}, out_d, 0);
    chk({p, "_out_user"}, out_u, 0);
    chk({p, "_locked"}, locked, 0);
    chk({p, "_err_geom"}, err_geom, 0);
    chk({p, "_err_count"}, err_count, 0);
    chk({p, "_meas_w"}, meas_w, 0);
    chk({p, "_meas_h"}, meas_h, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, ep, n;
    step(3);
    chk_zero("rst");
    resetn = 1'b1;
    step(1);
    chk("ready_after_rst", in_r, 1);
    // stream starting mid-frame: nothing passes before the first sof
    for (int l = 0; l < 3; l++) line(20);
    chk("hunt_locked", locked, 0);
    chk("hunt_out_cnt", out_cnt, 0);
    send(1, 1);
    chk("lock_n1", locked, 0);
    step(1);
    chk("lock_n2", locked, 1);
    // nominal frame
    frame_body(64);
    send(1, 1);
    drain;
    step(3);
    chk("f1_count", out_cnt, 3072);
    chk("f1_meas_w", meas_w, 64);
    chk("f1_meas_h", meas_h, 48);
    chk("f1_err_cnt", err_count, 0);
    chk("f1_locked", locked, 1);
    // output ready 1-of-3 with continuous input
    rdy_mode = 1;
    frame_body(64);
    send(1, 1);
    drain;
    rdy_mode = 0;
    step(3);
    chk("f2_stall", saw_stall, 1);
    chk("f2_count", out_cnt, 6144);
    chk("f2_meas_w", meas_w, 64);
    chk("f2_meas_h", meas_h, 48);
    // last line one pixel short
    c = out_cnt;
    ep = err_pulses;
    frame_body(63);
    step(3);
    chk("bad_meas_w", meas_w, 63);
`ifdef SVO_DEC_GEOM_CHECK_EN
    chk("bad_locked", locked, 0);
    chk("bad_err_cnt", err_count, 1);
    chk("bad_pulses", err_pulses - ep, 1);
`else
    chk("bad_locked", locked, 1);
    chk("bad_err_cnt", err_count, 0);
    chk("bad_pulses", err_pulses - ep, 0);
`endif
    send(1, 1);
    step(1);
    chk("relock", locked, 1);
    drain;
    chk("bad_count", out_cnt - c, 3071);
    frame_body(64);
    send(1, 1);
    drain;
    step(3);
    chk("f4_meas_w", meas_w, 64);
    chk("f4_meas_h", meas_h, 48);
`ifdef SVO_DEC_GEOM_CHECK_EN
    chk("f4_err_cnt", err_count, 1);
`else
    chk("f4_err_cnt", err_count, 0);
`endif
    // fill the FIFO with the output stalled, then reset mid-frame
    rdy_mode = 2;
    step(2);
    n = 0;
    while (n < 8 && in_r) begin
      send(0, 0);
      n++;
    end
    chk("stall_beats", n, 4);
    chk("stall_out_valid", out_v, 1);
    resetn = 1'b0;
    step(1);
    chk_zero("mid_rst");
    exp_q.delete();
    m_lock = 0;
    m_first = 0;
    m_prev_nb = 0;
    resetn = 1'b1;
    rdy_mode = 0;
    c = out_cnt;
    line(16);
    step(10);
    chk("no_stale", out_cnt - c, 0);
    chk("post_rst_locked", locked, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
